// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display sharing one registered decoder.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iEn,
   input  logic [4*DIGITS-1:0]   iDigits,
   input  logic                  iLoad,
   output logic [3:0]            oBCD,
   output logic [DIGITS-1:0]     oDigitEn,
   output logic                  oFrame
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK - 1);
   localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   pending_q, pending_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [3:0]            bcd_q, bcd_d;
   logic [DIGITS-1:0]     digit_en_q, digit_en_d;
   logic                  frame_q, frame_d;
   logic [3:0]            nib_d;
   logic                  suppress_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         pending_q  <= '0;
         shadow_q   <= '0;
         bcd_q      <= '0;
         digit_en_q <= '0;
         frame_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         pending_q  <= pending_d;
         shadow_q   <= shadow_d;
         bcd_q      <= bcd_d;
         digit_en_q <= digit_en_d;
         frame_q    <= frame_d;
      end
   end

   // Shadow only changes when a frame starts, so a frame in progress is never torn.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      pending_d = iLoad ? iDigits : pending_q;
      if (!iEn) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d  = ST_BLANK;
               cnt_d    = '0;
               idx_d    = '0;
               shadow_d = pending_d;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_BLANK_LAST) begin
                  state_d = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_BLANK;
                  if (idx_q == IDX_LAST) begin
                     idx_d    = '0;
                     shadow_d = pending_d;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      nib_d = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            nib_d = shadow_d[4*k +: 4];
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // lead_zero[k] is set when nibbles k..DIGITS-1 are all zero; digit 0 is never suppressed.
   logic [DIGITS-1:0] lead_zero;
   logic              above_zero;

   always_comb begin
      lead_zero  = '0;
      above_zero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         above_zero   = above_zero && (shadow_d[4*k +: 4] == 4'd0);
         lead_zero[k] = above_zero;
      end
   end

   assign suppress_d = lead_zero[idx_d];
`else
   assign suppress_d = 1'b0;
`endif

   // Outputs are computed from the next-state values so the registered outputs line up with the state.
   always_comb begin
      bcd_d      = bcd_q;
      digit_en_d = '0;
      frame_d    = 1'b0;
      if (state_d == ST_BLANK) begin
         bcd_d = nib_d;
      end
      if ((state_d == ST_SHOW) && (nib_d <= 4'd9) && !suppress_d) begin
         digit_en_d = DIGITS'(1) << idx_d;
      end
      if ((state_d == ST_SHOW) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST)) begin
         frame_d = 1'b1;
      end
   end

   assign oBCD     = bcd_q;
   assign oDigitEn = digit_en_q;
   assign oFrame   = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK=2.
// Expected lit masks depend on whether LEADING_ZERO_BLANK_EN is defined.
module tb_display_scan_ctrl;

   logic        clk;
   logic        rst;
   logic        iEn;
   logic [15:0] iDigits;
   logic        iLoad;
   logic [3:0]  oBCD;
   logic [3:0]  oDigitEn;
   logic        oFrame;

   int passCount;
   int failCount;
   int checkCount;

   logic [3:0] mask0070;
   logic [3:0] mask0000;

   display_scan_ctrl #(
      .DIGITS   (4),
      .PRESCALE (8),
      .BLANK    (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .iEn      (iEn),
      .iDigits  (iDigits),
      .iLoad    (iLoad),
      .oBCD     (oBCD),
      .oDigitEn (oDigitEn),
      .oFrame   (oFrame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Walks numCycles of a frame; litMask marks the slots that must light up after the 2 blank cycles.
   // When loadAt >= 0, loadValue is strobed on iLoad during that cycle.
   task automatic applyStimulus(input string tag, input logic [15:0] value, input logic [3:0] litMask,
                                input int numCycles, input int loadAt, input logic [15:0] loadValue);
      for (int i = 0; i < numCycles; i++) begin
         int s;
         int c;
         logic [3:0] expBCD;
         logic [3:0] expEn;
         logic       expFrame;
         @(posedge clk);
         #1;
         iLoad = 1'b0;
         s = (i / 8) % 4;
         c = i % 8;
         expBCD   = value[4*s +: 4];
         expEn    = ((c >= 2) && litMask[s]) ? (4'b0001 << s) : 4'b0000;
         expFrame = (s == 3) && (c == 7);
         checkOutput($sformatf("%s bcd s%0d c%0d", tag, s, c), {12'd0, oBCD}, {12'd0, expBCD});
         checkOutput($sformatf("%s en s%0d c%0d", tag, s, c), {12'd0, oDigitEn}, {12'd0, expEn});
         checkOutput($sformatf("%s frame s%0d c%0d", tag, s, c), {15'd0, oFrame}, {15'd0, expFrame});
         if (i == loadAt) begin
            iDigits = loadValue;
            iLoad   = 1'b1;
         end
      end
   endtask

   initial begin
      passCount  = 0;
      failCount  = 0;
      checkCount = 0;
`ifdef LEADING_ZERO_BLANK_EN
      mask0070 = 4'b0011;
      mask0000 = 4'b0001;
`else
      mask0070 = 4'b1111;
      mask0000 = 4'b1111;
`endif
      rst     = 1'b1;
      iEn     = 1'b0;
      iLoad   = 1'b0;
      iDigits = 16'h0000;

      #1;
      checkOutput("reset bcd", {12'd0, oBCD}, 16'h0);
      checkOutput("reset en", {12'd0, oDigitEn}, 16'h0);
      checkOutput("reset frame", {15'd0, oFrame}, 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle with scan disabled stays dark.
      @(posedge clk);
      #1;
      checkOutput("idle en", {12'd0, oDigitEn}, 16'h0);

      // Load 1234 while idle, then enable: two full frames.
      iDigits = 16'h1234;
      iLoad   = 1'b1;
      @(posedge clk);
      #1;
      iLoad = 1'b0;
      checkOutput("idle after load en", {12'd0, oDigitEn}, 16'h0);
      iEn = 1'b1;
      $display("[TB] frame 1234");
      applyStimulus("f1234a", 16'h1234, 4'b1111, 32, -1, 16'h0);
      applyStimulus("f1234b", 16'h1234, 4'b1111, 32, -1, 16'h0);

      // Mid-frame load in slot 1 must not tear the current frame.
      applyStimulus("f1234c", 16'h1234, 4'b1111, 32, 11, 16'h5678);
      // Load coincident with the oFrame cycle reaches the very next frame.
      applyStimulus("f5678", 16'h5678, 4'b1111, 32, 31, 16'h1A34);
      applyStimulus("f1a34", 16'h1A34, 4'b1011, 32, -1, 16'h0);

      // Drop iEn at cycle 4 of slot 2.
      applyStimulus("f1a34drop", 16'h1A34, 4'b1011, 21, -1, 16'h0);
      iEn = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("drop en", {12'd0, oDigitEn}, 16'h0);
      checkOutput("drop bcd hold", {12'd0, oBCD}, 16'h000A);
      checkOutput("drop frame", {15'd0, oFrame}, 16'h0);
      @(posedge clk);
      #1;
      checkOutput("idle2 en", {12'd0, oDigitEn}, 16'h0);
      iEn = 1'b1;
      applyStimulus("reenable", 16'h1A34, 4'b1011, 32, -1, 16'h0);

      // Leading zeros: 0070 loaded while idle.
      iEn = 1'b0;
      iDigits = 16'h0070;
      iLoad   = 1'b1;
      @(posedge clk);
      #1;
      iLoad = 1'b0;
      iEn   = 1'b1;
      applyStimulus("f0070", 16'h0070, mask0070, 32, -1, 16'h0);

      // Value zero loaded in the same cycle as enable.
      iEn = 1'b0;
      @(posedge clk);
      #1;
      iDigits = 16'h0000;
      iLoad   = 1'b1;
      iEn     = 1'b1;
      applyStimulus("f0000", 16'h0000, mask0000, 32, 31, 16'h1234);

      // Async reset while slot 1 is lit.
      applyStimulus("prereset", 16'h1234, 4'b1111, 12, -1, 16'h0);
      checkOutput("prereset en", {12'd0, oDigitEn}, 16'h0002);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst en", {12'd0, oDigitEn}, 16'h0);
      checkOutput("async rst bcd", {12'd0, oBCD}, 16'h0);
      checkOutput("async rst frame", {15'd0, oFrame}, 16'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus("postreset", 16'h0000, mask0000, 3, -1, 16'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display. Several digits share one registered BCD-to-7-segment decoder (1-cycle latency). The block drives the shared decoder's BCD input, sequences the per-digit enables, and inserts dead-time so that no digit shows stale segments. It sits between the value-producing logic and the decoder/digit drivers.

Parameters:
DIGITS, 4, number of digits scanned; digit 0 is least significant.
PRESCALE, 50000, clk cycles per digit slot, including dead-time; must be > BLANK.
BLANK, 16, dead-time cycles at the start of each slot; must be >= 2 to cover decoder latency.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
iEn  input  1  scan enable; 0 = display dark, FSM idle
iDigits  input  4*DIGITS  packed BCD value; nibble k = digit k
iLoad  input  1  1-cycle strobe; captures iDigits into the pending register
oBCD  output  4  BCD nibble to the shared decoder
oDigitEn  output  DIGITS  one-hot digit enable, active-high; all-zero when dark
oFrame  output  1  1-cycle pulse on the last cycle of digit DIGITS-1

Behaviour:
- Reset (async, rst=1) forces: state IDLE, cnt=0, idx=0, pending=0, shadow=0, oBCD=0, oDigitEn=0, oFrame=0. Reset may occur in any state; all outputs clear immediately.
- All outputs are registered; there is no combinational path from input to output.
- Registers: pending (loaded on iLoad), shadow (displayed value), slot counter cnt 0..PRESCALE-1, digit index idx 0..DIGITS-1.
- States: IDLE, BLANK, SHOW.
- IDLE: oDigitEn=0, oBCD holds its value. When iEn=1: shadow<=pending (or iDigits if iLoad is asserted in the same cycle), idx=0, cnt=0, go to BLANK.
- BLANK: oDigitEn=0. oBCD<=shadow nibble idx on entry. cnt counts up; when cnt=BLANK-1, go to SHOW. The decoder output is therefore stable before the digit is enabled.
- SHOW: oDigitEn=one-hot(idx), unless the digit is suppressed (see below). When cnt=PRESCALE-1: cnt<=0 and go to BLANK with the next idx.
- Wrap: at SHOW end with idx=DIGITS-1: idx<=0, oFrame=1 for that cycle, and shadow<=pending.
- Simultaneous iLoad and wrap: the iDigits value in that cycle goes directly into shadow.
- iLoad mid-frame updates pending only. The frame in progress is never torn.
- Invalid nibble (>9): oBCD is still driven, but oDigitEn stays 0 for that whole slot (digit dark). The decoder defines no pattern for these codes.
- iEn=0 in any state: the next cycle is IDLE with oDigitEn=0, cnt=0, idx=0. Re-enable always starts at digit 0 BLANK.
- Frame period = DIGITS*PRESCALE cycles. Each digit is lit for PRESCALE-BLANK cycles per frame.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, any digit k>0 is suppressed (oDigitEn=0) if shadow nibbles k..DIGITS-1 are all 0. Digit 0 is always shown, so a value of 0 displays a single "0". Suppression is evaluated on the shadow value, so it is stable for the whole frame.
- Undefined: every valid digit is shown, including leading zeros. Suppression logic is not synthesized.

Test Plan:
Simulation parameters: DIGITS=4, PRESCALE=8, BLANK=2.
1. rst pulsed while in SHOW with oDigitEn=0010 -> oDigitEn=0000, oBCD=0, oFrame=0 with no clk edge; after rst release with iEn=1, slot 0 BLANK starts.
2. iDigits=16'h1234, iLoad, then iEn=1 -> slot 0: oBCD=4, oDigitEn=0000 for 2 cycles, then 0001 for 6 cycles. Slots 1/2/3 follow as 3/0010, 2/0100, 1/1000. oFrame pulses on the 32nd cycle; the pattern repeats with period 32.
3. During slot 1 of the 16'h1234 frame, iLoad with 16'h5678 -> slots 2,3 still show 2,1. The next frame shows 8,7,6,5. iLoad coincident with the oFrame cycle -> the next frame already shows the new value.
4. iDigits=16'h1A34 -> slot 2 has oBCD=A and oDigitEn=0000 for all 8 cycles; the other slots are normal.
5. iEn dropped at cycle 4 of slot 2 -> next cycle oDigitEn=0000, state IDLE. iEn reasserted -> oBCD=digit 0, 2 blank cycles, then oDigitEn=0001.
6. iDigits=16'h0070 -> with LEADING_ZERO_BLANK_EN, slots 3,2 stay dark, slot 1 shows 7, slot 0 shows 0. Without the macro, all four are lit (0,0,7,0). With iDigits=0 and the macro, only slot 0 is lit.
